// File: rtl/bus_cycle_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bus_ctrl_pkg                                               |
// | Brief   : Shared types and constants for the bus cycle controller.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package bus_ctrl_pkg;

  // Bus ownership / phase of the current access
  typedef enum logic [1:0] {
    S_CPU      = 2'd0,
    S_CPU_WAIT = 2'd1,
    S_DMA      = 2'd2,
    S_DMA_WAIT = 2'd3
  } bus_state_t;

  // Address bit selecting the slow region
  localparam int REGION_BIT = 15;

  // Bus direction encoding
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

endpackage
`default_nettype wire

// File: rtl/bus_cycle_controller_wait_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : wait_counter                                               |
// | Brief   : Loadable down-counter, saturating at zero, with zero flag. |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module wait_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  // Load has priority; decrement stops at zero so a ready stretch holds it there
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/bus_cycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bus_cycle_controller                                       |
// | Brief   : Sequences CPU bus cycles with region wait states and       |
// |           ext_ready stretching; arbitrates bursts for a DMA master.  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module bus_cycle_controller
  import bus_ctrl_pkg::*;
#(
  parameter int WAIT_W    = 3,
  parameter int DMA_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       cpu_addr,
  input  logic              cpu_rw,
  input  logic              instr_boundary,
  input  logic              dma_req,
  input  logic [15:0]       dma_addr,
  input  logic              dma_rw,
  input  logic              ext_ready,
  input  logic [WAIT_W-1:0] wait_fast,
  input  logic [WAIT_W-1:0] wait_slow,
  output logic              enableFFs,
  output logic              dma_gnt,
  output logic              dma_done,
  output logic [15:0]       bus_addr,
  output logic              bus_rw,
  output logic              bus_strobe
);

  localparam int BURST_W = $clog2(DMA_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(DMA_BURST);

  bus_state_t          state;
  bus_state_t          done_state;
  logic [BURST_W-1:0]  burst;
  logic [BURST_W-1:0]  burst_next;
  logic [BURST_W-1:0]  done_burst;
  logic [15:0]         hold_addr;
  logic                hold_rw;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                wait_zero;
  logic                is_dma;
  logic                first;
  logic [15:0]         live_addr;
  logic                live_rw;
  logic [WAIT_W-1:0]   w;
  logic                complete;

  assign is_dma     = (state == S_DMA) || (state == S_DMA_WAIT);
  assign first      = (state == S_CPU) || (state == S_DMA);
  assign live_addr  = is_dma ? dma_addr : cpu_addr;
  assign live_rw    = is_dma ? dma_rw   : cpu_rw;
  // W only matters on an access's first cycle; later cycles run off the counter
  assign w          = live_addr[REGION_BIT] ? wait_slow : wait_fast;
  assign complete   = ext_ready && (first ? (w == '0) : wait_zero);
  assign burst_next = burst + BURST_W'(1);

  wait_counter #(.WIDTH(WAIT_W)) u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (first && (w != '0)),
    .load_val (w - 1'b1),
    .dec      (!first),
    .count    (wait_cnt),
    .zero     (wait_zero)
  );

  // Decide the next owner once the current access completes
  always_comb begin
    done_state = S_CPU;
    done_burst = burst;
    if (!is_dma) begin
      if (instr_boundary && dma_req) begin
        done_state = S_DMA;
        done_burst = '0;
      end
    end else begin
      done_burst = burst_next;
      if (dma_req && (burst_next < BURST_MAX)) begin
        done_state = S_DMA;
      end
    end
  end

  // Access sequencing: latch address on the first cycle, wait, then hand over
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_CPU;
      burst     <= '0;
      hold_addr <= '0;
      hold_rw   <= WRITE;
    end else begin
      unique case (state)
        S_CPU, S_DMA: begin
          hold_addr <= live_addr;
          hold_rw   <= live_rw;
          if (w != '0) begin
            state <= is_dma ? S_DMA_WAIT : S_CPU_WAIT;
          end else if (complete) begin
            state <= done_state;
            burst <= done_burst;
          end
        end
        S_CPU_WAIT, S_DMA_WAIT: begin
          if (complete) begin
            state <= done_state;
            burst <= done_burst;
          end
        end
        default: state <= S_CPU;
      endcase
    end
  end

  // Outputs are forced idle while reset is held
  always_comb begin
    enableFFs  = !rst && !is_dma && complete;
    dma_done   = !rst && is_dma && complete;
    dma_gnt    = !rst && is_dma;
    bus_strobe = !rst;
    bus_addr   = rst ? 16'h0000 : (first ? live_addr : hold_addr);
    bus_rw     = rst ? READ : (first ? live_rw : hold_rw);
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_cycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_bus_cycle_controller                                    |
// | Brief   : Directed + random bench with an access-level model.        |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_bus_cycle_controller;

  localparam int WAIT_W    = 3;
  localparam int DMA_BURST = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       cpu_addr;
  logic              cpu_rw;
  logic              instr_boundary;
  logic              dma_req;
  logic [15:0]       dma_addr;
  logic              dma_rw;
  logic              ext_ready;
  logic [WAIT_W-1:0] wait_fast;
  logic [WAIT_W-1:0] wait_slow;
  logic              enableFFs;
  logic              dma_gnt;
  logic              dma_done;
  logic [15:0]       bus_addr;
  logic              bus_rw;
  logic              bus_strobe;

  bus_cycle_controller #(.WAIT_W(WAIT_W), .DMA_BURST(DMA_BURST)) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_addr       (cpu_addr),
    .cpu_rw         (cpu_rw),
    .instr_boundary (instr_boundary),
    .dma_req        (dma_req),
    .dma_addr       (dma_addr),
    .dma_rw         (dma_rw),
    .ext_ready      (ext_ready),
    .wait_fast      (wait_fast),
    .wait_slow      (wait_slow),
    .enableFFs      (enableFFs),
    .dma_gnt        (dma_gnt),
    .dma_done       (dma_done),
    .bus_addr       (bus_addr),
    .bus_rw         (bus_rw),
    .bus_strobe     (bus_strobe)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_done = 0;

  // Access-level model: who owns the bus, whether an access is in flight,
  // the address it latched and how many wait cycles it still owes.
  bit          m_dma    = 1'b0;
  bit          m_busy   = 1'b0;
  logic [15:0] m_addr   = 16'h0;
  logic        m_rw     = 1'b1;
  int          m_waits  = 0;
  int          m_burst  = 0;
  bit          last_adv = 1'b1;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h @%0t", tag, act, exp, $time);
    end
  endtask

  // Inputs are already driven; check mid-cycle, advance model, move to next cycle
  task automatic cycle();
    bit comp;
    #3;
    if (dma_done === 1'b1) n_done++;
    if (rst) begin
      chk("rst_en",     {15'd0, enableFFs},  16'd0);
      chk("rst_gnt",    {15'd0, dma_gnt},    16'd0);
      chk("rst_done",   {15'd0, dma_done},   16'd0);
      chk("rst_strobe", {15'd0, bus_strobe}, 16'd0);
      chk("rst_addr",   bus_addr,            16'h0000);
      chk("rst_rw",     {15'd0, bus_rw},     16'd1);
      m_dma = 0; m_busy = 0; m_burst = 0; m_waits = 0;
      last_adv = 1'b1;
    end else begin
      if (!m_busy) begin
        m_addr  = m_dma ? dma_addr : cpu_addr;
        m_rw    = m_dma ? dma_rw : cpu_rw;
        m_waits = int'(m_addr[15] ? wait_slow : wait_fast);
      end
      comp = (m_waits == 0) && ext_ready;
      chk("en",     {15'd0, enableFFs},  {15'd0, comp && !m_dma});
      chk("done",   {15'd0, dma_done},   {15'd0, comp && m_dma});
      chk("gnt",    {15'd0, dma_gnt},    {15'd0, m_dma});
      chk("strobe", {15'd0, bus_strobe}, 16'd1);
      chk("addr",   bus_addr,            m_addr);
      chk("rw",     {15'd0, bus_rw},     {15'd0, m_rw});
      last_adv = comp && !m_dma;
      if (comp) begin
        m_busy = 0;
        if (!m_dma) begin
          if (instr_boundary && dma_req) begin
            m_dma = 1; m_burst = 0;
          end
        end else begin
          m_burst++;
          if (!(dma_req && m_burst < DMA_BURST)) m_dma = 0;
        end
      end else if (m_waits > 0) begin
        m_busy = 1;
        m_waits--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    rst = 1; cpu_addr = 16'h0200; cpu_rw = 1; instr_boundary = 0;
    dma_req = 0; dma_addr = 16'h1234; dma_rw = 0; ext_ready = 1;
    wait_fast = 0; wait_slow = 2;
    @(posedge clk); #1;

    // Reset, then fast region at full throughput
    cycles(2);
    rst = 0;
    cycles(5);

    // Slow region with two wait states
    cpu_addr = 16'h8000;
    cycles(6);

    // ext_ready held low for three cycles
    cpu_addr = 16'h0200;
    ext_ready = 0;
    cycles(3);
    ext_ready = 1;
    cycles(2);

    // DMA request mid-instruction, granted at the boundary, full burst
    dma_req = 1; dma_addr = 16'h1234;
    cycles(3);
    instr_boundary = 1;
    cycle();
    instr_boundary = 0;
    n_done = 0;
    cycles(8);
    chk("burst_count", 16'(n_done), 16'd4);
    dma_req = 0;
    cycles(2);

    // Early release after one transfer
    dma_req = 1; instr_boundary = 1;
    cycle();
    instr_boundary = 0; dma_req = 0;
    n_done = 0;
    cycles(4);
    chk("early_count", 16'(n_done), 16'd1);

    // Reset while a slow DMA transfer is waiting
    wait_slow = 3; dma_addr = 16'h9000; dma_req = 1; instr_boundary = 1;
    cycle();
    instr_boundary = 0;
    n_done = 0;
    cycles(2);
    rst = 1;
    cycle();
    rst = 0; dma_req = 0;
    chk("rst_dma_done", 16'(n_done), 16'd0);
    cycles(3);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      rst       = ($urandom_range(0, 149) == 0);
      cpu_addr  = 16'($urandom);
      cpu_rw    = 1'($urandom);
      dma_addr  = 16'($urandom);
      dma_rw    = 1'($urandom);
      ext_ready = ($urandom_range(0, 3) != 0);
      wait_fast = WAIT_W'($urandom_range(0, 2));
      wait_slow = WAIT_W'($urandom_range(0, 4));
      if (last_adv) instr_boundary = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) dma_req = ~dma_req;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
